// File: rtl/alu_frame_decoder.sv
// alu_frame_decoder
//   Decodes a byte-serial command stream into ALU operations. Each frame is
//   three bytes: an opcode byte (low nibble selects the operation, high nibble
//   ignored), operand A, then operand B. The result is registered when B is
//   accepted and held until downstream takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    command-stream byte
//   in_valid   in_data valid this cycle
//   in_ready   decoder accepts a byte this cycle
//   res_data   operation result
//   res_carry  carry/borrow of add/sub, else 0
//   res_err    opcode was illegal (sel 8..15)
//   res_valid  res_data/res_carry/res_err valid
//   res_ready  downstream accepts the result
//   frame_cnt  count of completed (handed-off) frames, wraps at 0xFF
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1,
// on both the input byte port (in_valid/in_ready) and the result port
// (res_valid/res_ready). valid is never withdrawn by this block once raised,
// and the payload is held stable until the transfer.

module alu_frame_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] res_data,
   output logic       res_carry,
   output logic       res_err,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] frame_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GET_A = 2'd1,
      GET_B = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       in_fire;
   logic       res_fire;
   logic [3:0] sel_q;
   logic [7:0] a_q;
   logic [8:0] alu_res;
   logic       alu_err;

   assign in_fire  = in_valid & in_ready;
   assign res_fire = res_valid & res_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_fire)  state_nxt = GET_A;
         GET_A:   if (in_fire)  state_nxt = GET_B;
         GET_B:   if (in_fire)  state_nxt = RESP;
         RESP:    if (res_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: the input port closes exactly while a result is pending,
   // so no byte can be taken on the handoff edge.
   always_comb begin
      in_ready  = (state != RESP);
      res_valid = (state == RESP);
   end

   // ALU on the captured opcode/operand A and the incoming operand B byte.
   // Bit 8 of the 9-bit subtract is the borrow, set exactly when A < B.
   always_comb begin
      alu_res = 9'd0;
      alu_err = 1'b0;
      case (sel_q)
         4'd0:    alu_res = {1'b0, a_q} + {1'b0, in_data};
         4'd1:    alu_res = {1'b0, a_q} - {1'b0, in_data};
         4'd2:    alu_res = {1'b0, a_q & in_data};
         4'd3:    alu_res = {1'b0, a_q | in_data};
         4'd4:    alu_res = {1'b0, a_q ^ in_data};
         4'd5:    alu_res = {1'b0, ~a_q};
         4'd6:    alu_res = {1'b0, a_q[6:0], 1'b0};
         4'd7:    alu_res = {2'b00, a_q[7:1]};
         default: alu_err = 1'b1;
      endcase
   end

   // Frame capture, result register and handoff counter. Results load only
   // on the B transfer, which keeps them stable for the whole RESP stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q     <= 4'd0;
         a_q       <= 8'd0;
         res_data  <= 8'd0;
         res_carry <= 1'b0;
         res_err   <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         if (in_fire && state == IDLE) begin
            sel_q <= in_data[3:0];
         end
         if (in_fire && state == GET_A) begin
            a_q <= in_data;
         end
         if (in_fire && state == GET_B) begin
            res_data  <= alu_res[7:0];
            res_carry <= alu_res[8];
            res_err   <= alu_err;
         end
         if (res_fire) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_frame_decoder.sv
// tb_alu_frame_decoder
//   Directed-vector bench for alu_frame_decoder. Inputs change on the falling
//   edge and outputs are sampled there, half a cycle away from the active edge.

module tb_alu_frame_decoder;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic       res_err;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] frame_cnt;

   int         vectors;
   int         miscompares;
   logic [7:0] exp_cnt;

   alu_frame_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_data  (res_data),
      .res_carry (res_carry),
      .res_err   (res_err),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .frame_cnt (frame_cnt)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one byte and hold it until the decoder takes it (bounded wait).
   // Returns at the falling edge after the accepting rising edge.
   task automatic send_byte(input logic [7:0] d);
      int n;
      n        = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_timeout", 16'(n < 20), 16'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Full frame with optional in_valid gaps, result check and handoff.
   task automatic run_frame(input string tag, input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input int gap, input logic [7:0] e_data,
                            input logic e_carry, input logic e_err);
      send_byte(op);
      idle(gap);
      send_byte(a);
      idle(gap);
      send_byte(b);
      chk({tag, "_valid_lat"}, 16'(res_valid), 16'd1);
      chk({tag, "_in_ready"},  16'(in_ready),  16'd0);
      chk({tag, "_data"},      16'(res_data),  16'(e_data));
      chk({tag, "_carry"},     16'(res_carry), 16'(e_carry));
      chk({tag, "_err"},       16'(res_err),   16'(e_err));
      chk({tag, "_cnt_hold"},  16'(frame_cnt), 16'(exp_cnt));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_cnt   = exp_cnt + 8'd1;
      chk({tag, "_cnt_inc"},   16'(frame_cnt), 16'(exp_cnt));
      chk({tag, "_valid_off"}, 16'(res_valid), 16'd0);
      chk({tag, "_ready_on"},  16'(in_ready),  16'd1);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"},  16'(in_ready),  16'd1);
      chk({tag, "_res_valid"}, 16'(res_valid), 16'd0);
      chk({tag, "_res_data"},  16'(res_data),  16'h00);
      chk({tag, "_res_carry"}, 16'(res_carry), 16'd0);
      chk({tag, "_res_err"},   16'(res_err),   16'd0);
      chk({tag, "_frame_cnt"}, 16'(frame_cnt), 16'h00);
   endtask

   initial begin
      int s;
      vectors     = 0;
      miscompares = 0;
      exp_cnt     = 8'd0;
      rst         = 1'b1;
      in_data     = 8'h00;
      in_valid    = 1'b0;
      res_ready   = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_values("por");
      rst = 1'b0;
      @(negedge clk);

      // res_ready with nothing pending is ignored
      res_ready = 1'b1;
      repeat (3) @(negedge clk);
      res_ready = 1'b0;
      chk("idle_ready_cnt",   16'(frame_cnt), 16'h00);
      chk("idle_ready_valid", 16'(res_valid), 16'd0);

      // Arithmetic, logic, shifts, upper-nibble masking, illegal opcodes
      run_frame("add_carry", 8'h00, 8'hF0, 8'h20, 0, 8'h10, 1'b1, 1'b0);
      run_frame("sub_pos",   8'h01, 8'h05, 8'h03, 0, 8'h02, 1'b0, 1'b0);
      run_frame("sub_neg",   8'h01, 8'h03, 8'h05, 2, 8'hFE, 1'b1, 1'b0);
      run_frame("sub_eq",    8'h01, 8'h5A, 8'h5A, 0, 8'h00, 1'b0, 1'b0);
      run_frame("and",       8'h02, 8'hAC, 8'h0F, 1, 8'h0C, 1'b0, 1'b0);
      run_frame("or",        8'h03, 8'hA0, 8'h05, 0, 8'hA5, 1'b0, 1'b0);
      run_frame("xor",       8'h04, 8'hFF, 8'h0F, 3, 8'hF0, 1'b0, 1'b0);
      run_frame("not",       8'h05, 8'h3C, 8'h77, 0, 8'hC3, 1'b0, 1'b0);
      run_frame("shl",       8'h06, 8'h81, 8'hEE, 0, 8'h02, 1'b0, 1'b0);
      run_frame("shr",       8'h07, 8'h81, 8'h99, 0, 8'h40, 1'b0, 1'b0);
      run_frame("hi_nibble", 8'hF5, 8'h0F, 8'h00, 0, 8'hF0, 1'b0, 1'b0);
      run_frame("illegal9",  8'h09, 8'h12, 8'h34, 0, 8'h00, 1'b0, 1'b1);
      run_frame("illegalF",  8'h0F, 8'hFF, 8'hFF, 1, 8'h00, 1'b0, 1'b1);
      run_frame("add_max",   8'h00, 8'hFF, 8'hFF, 0, 8'hFE, 1'b1, 1'b0);

      // Backpressure in RESP with a byte offered
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h01);
      in_data  = 8'h07;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 16'(in_ready),  16'd0);
         chk("stall_valid",    16'(res_valid), 16'd1);
         chk("stall_data",     16'(res_data),  16'h02);
         chk("stall_carry",    16'(res_carry), 16'd0);
         chk("stall_cnt",      16'(frame_cnt), 16'(exp_cnt));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_cnt   = exp_cnt + 8'd1;
      chk("stall_handoff_cnt", 16'(frame_cnt), 16'(exp_cnt));
      chk("stall_idle_ready",  16'(in_ready),  16'd1);
      // 0x07 still offered: taken as the opcode on this next edge
      @(negedge clk);
      in_valid = 1'b0;
      send_byte(8'h81);
      send_byte(8'h55);
      chk("post_stall_valid", 16'(res_valid), 16'd1);
      chk("post_stall_data",  16'(res_data),  16'h40);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_cnt   = exp_cnt + 8'd1;
      chk("post_stall_cnt", 16'(frame_cnt), 16'(exp_cnt));

      // Reset mid-frame: asynchronous, checked before the next clock edge
      send_byte(8'h00);
      send_byte(8'h11);
      rst = 1'b1;
      #1;
      chk_reset_values("mid_rst");
      @(negedge clk);
      rst     = 1'b0;
      exp_cnt = 8'd0;
      run_frame("after_rst", 8'h03, 8'h0F, 8'hF0, 0, 8'hFF, 1'b0, 1'b0);

      // 255 more handoffs: 256 total since reset, counter wraps to zero
      for (int i = 0; i < 255; i++) begin
         s = i + 240;
         run_frame("wrap", 8'h00, 8'(i), 8'hF0, 0, 8'(s), (s >= 256) ? 1'b1 : 1'b0, 1'b0);
      end
      chk("frame_cnt_wrap", 16'(frame_cnt), 16'h00);

      // Reset while a result is pending
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h01);
      chk("resp_pre_rst_valid", 16'(res_valid), 16'd1);
      rst = 1'b1;
      #1;
      chk_reset_values("resp_rst");
      @(negedge clk);
      rst     = 1'b0;
      exp_cnt = 8'd0;
      run_frame("after_resp_rst", 8'h04, 8'hF0, 8'hFF, 0, 8'h0F, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time limit so the run always ends with a summary
   initial begin
      #200000;
      miscompares++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
